// File: rtl/adder32_share_ctrl.sv
// Sequences one shared 16-bit adder twice (low, then high half) to produce a
// 32-bit add/subtract for one of two arbitrated requesters.
module adder32_share_ctrl #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [1:0]  req_sub,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_r,
  output logic        rsp_cout,
  output logic        rsp_ovf,
  output logic [15:0] add_A,
  output logic [15:0] add_B,
  output logic        add_cin,
  input  logic [15:0] add_R
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state_q, state_d;
  logic        rr_q;
  logic        grant;
  logic        accept;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        sub_q;
  logic        id_q;
  logic [15:0] r_lo_q;
  logic        c16_q;
  logic [31:0] r_q;
  logic        cout_q;
  logic        ovf_q;
  logic        carry15;
  logic        ovf15;

  // rr_q names the requester that wins a tie in round-robin mode.
  always_comb begin
    grant = 1'b0;
    if (FAIR) begin
      grant = req_valid[rr_q] ? rr_q : ~rr_q;
    end else begin
      grant = ~req_valid[0];
    end
    req_ready = 2'b00;
    if (state_q == IDLE && (|req_valid)) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign accept = (state_q == IDLE) && req_valid[grant];

  always_comb begin
    add_A   = 16'h0000;
    add_B   = 16'h0000;
    add_cin = 1'b0;
    case (state_q)
      LO: begin
        add_A   = a_q[15:0];
        add_B   = b_q[15:0];
        add_cin = sub_q;
      end
      HI: begin
        add_A   = a_q[31:16];
        add_B   = b_q[31:16];
        add_cin = c16_q;
      end
      default: ;
    endcase
  end

  // The adder has no carry-out; recover it from the top operand and sum bits.
  assign carry15 = (add_A[15] & add_B[15]) | ((add_A[15] | add_B[15]) & ~add_R[15]);
  assign ovf15   = (add_A[15] == add_B[15]) & (add_R[15] != add_A[15]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LO;
      LO:      state_d = HI;
      HI:      state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      sub_q   <= 1'b0;
      id_q    <= 1'b0;
      r_lo_q  <= 16'h0;
      c16_q   <= 1'b0;
      r_q     <= 32'h0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        id_q  <= grant;
        sub_q <= req_sub[grant];
        a_q   <= grant ? req_a1 : req_a0;
        // Subtract is a + ~b + 1; the +1 enters as the low-pass carry-in.
        b_q   <= (grant ? req_b1 : req_b0) ^ {32{req_sub[grant]}};
        rr_q  <= ~grant;
      end
      if (state_q == LO) begin
        r_lo_q <= add_R;
        c16_q  <= carry15;
      end
      if (state_q == HI) begin
        r_q    <= {add_R, r_lo_q};
        cout_q <= carry15;
        ovf_q  <= ovf15;
      end
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_id    = id_q;
  assign rsp_r     = r_q;
  assign rsp_cout  = cout_q;
  assign rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_adder32_share_ctrl.sv
// Bench: two controllers (round-robin and fixed priority), each with its own
// behavioural 16-bit adder, checked every cycle against an arithmetic model.
module tb_adder32_share_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic [1:0]  rv    [2];
  logic [1:0]  rdy   [2];
  logic [31:0] a0    [2];
  logic [31:0] b0    [2];
  logic [31:0] a1    [2];
  logic [31:0] b1    [2];
  logic [1:0]  sb    [2];
  logic        vld   [2];
  logic        rrdy  [2];
  logic        rid   [2];
  logic [31:0] rr    [2];
  logic        rco   [2];
  logic        rov   [2];
  logic [15:0] aA    [2];
  logic [15:0] aB    [2];
  logic [15:0] aR    [2];
  logic        acin  [2];

  int errors = 0;
  int checks = 0;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      assign aR[gi] = aA[gi] + aB[gi] + {15'b0, acin[gi]};
      adder32_share_ctrl #(.FAIR(gi == 0)) u_dut (
        .clk       (clk),
        .reset     (rst[gi]),
        .req_valid (rv[gi]),
        .req_ready (rdy[gi]),
        .req_a0    (a0[gi]),
        .req_b0    (b0[gi]),
        .req_a1    (a1[gi]),
        .req_b1    (b1[gi]),
        .req_sub   (sb[gi]),
        .rsp_valid (vld[gi]),
        .rsp_ready (rrdy[gi]),
        .rsp_id    (rid[gi]),
        .rsp_r     (rr[gi]),
        .rsp_cout  (rco[gi]),
        .rsp_ovf   (rov[gi]),
        .add_A     (aA[gi]),
        .add_B     (aB[gi]),
        .add_cin   (acin[gi]),
        .add_R     (aR[gi])
      );
    end
  endgenerate

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event at %0t", name, $time);
  endtask

  // Reference model state, one copy per instance.
  bit          live   [2];
  bit          busy   [2];
  int          age    [2];
  logic [31:0] ma     [2];
  logic [31:0] mb     [2];
  bit          msub   [2];
  bit          mid    [2];
  bit          ptr    [2];
  bit          jr     [2];
  int          gq0[$];
  int          gq1[$];

  always @(negedge clk) begin
    logic [31:0] er;
    logic [32:0] s33;
    logic [16:0] lo;
    logic [31:0] bx;
    longint      fs;
    logic        eco, eov;
    logic [1:0]  erdy;
    int          g;
    for (int k = 0; k < 2; k++) begin
      if (live[k]) begin
        bx  = msub[k] ? ~mb[k] : mb[k];
        er  = msub[k] ? (ma[k] - mb[k]) : (ma[k] + mb[k]);
        s33 = {1'b0, ma[k]} + {1'b0, mb[k]};
        eco = msub[k] ? (ma[k] >= mb[k]) : s33[32];
        fs  = msub[k] ? (longint'($signed(ma[k])) - longint'($signed(mb[k])))
                      : (longint'($signed(ma[k])) + longint'($signed(mb[k])));
        eov = (fs != longint'($signed(er)));
        lo  = {1'b0, ma[k][15:0]} + {1'b0, bx[15:0]} + {16'b0, msub[k]};

        g = -1;
        if (k == 0) begin
          if (rv[k][ptr[k]]) g = int'(ptr[k]);
          else if (rv[k][!ptr[k]]) g = int'(!ptr[k]);
        end else begin
          if (rv[k][0]) g = 0;
          else if (rv[k][1]) g = 1;
        end
        erdy = (!busy[k] && g >= 0) ? 2'(1 << g) : 2'b00;

        chk($sformatf("u%0d req_ready", k), 32'(rdy[k]), 32'(erdy));
        chk($sformatf("u%0d rsp_valid", k), 32'(vld[k]), 32'(busy[k] && age[k] >= 3));
        if (busy[k] && age[k] >= 3) begin
          chk($sformatf("u%0d rsp_r", k), rr[k], er);
          chk($sformatf("u%0d rsp_cout", k), 32'(rco[k]), 32'(eco));
          chk($sformatf("u%0d rsp_ovf", k), 32'(rov[k]), 32'(eov));
          chk($sformatf("u%0d rsp_id", k), 32'(rid[k]), 32'(mid[k]));
        end
        if (busy[k] && age[k] == 1) begin
          chk($sformatf("u%0d LO add_A", k), 32'(aA[k]), 32'(ma[k][15:0]));
          chk($sformatf("u%0d LO add_B", k), 32'(aB[k]), 32'(bx[15:0]));
          chk($sformatf("u%0d LO add_cin", k), 32'(acin[k]), 32'(msub[k]));
        end else if (busy[k] && age[k] == 2) begin
          chk($sformatf("u%0d HI add_A", k), 32'(aA[k]), 32'(ma[k][31:16]));
          chk($sformatf("u%0d HI add_B", k), 32'(aB[k]), 32'(bx[31:16]));
          chk($sformatf("u%0d HI add_cin", k), 32'(acin[k]), 32'(lo[16]));
        end else begin
          chk($sformatf("u%0d idle adder", k), {15'b0, acin[k], aA[k]} | 32'(aB[k]), 32'h0);
        end
        if (jr[k]) begin
          chk($sformatf("u%0d reset rsp", k),
              {rr[k] | {29'b0, rco[k], rov[k], rid[k]}}, 32'h0);
          jr[k] = 1'b0;
        end
      end

      // Advance the model across the coming clock edge.
      if (rst[k]) begin
        live[k] = 1'b1;
        busy[k] = 1'b0;
        age[k]  = 0;
        ptr[k]  = 1'b0;
        jr[k]   = 1'b1;
      end else if (live[k]) begin
        if (busy[k]) begin
          if (age[k] >= 3 && rrdy[k]) busy[k] = 1'b0;
          else age[k]++;
        end else if (g >= 0) begin
          busy[k] = 1'b1;
          age[k]  = 1;
          mid[k]  = g[0];
          ma[k]   = g[0] ? a1[k] : a0[k];
          mb[k]   = g[0] ? b1[k] : b0[k];
          msub[k] = sb[k][g[0]];
          ptr[k]  = !g[0];
          if (k == 0) gq0.push_back(g);
          else gq1.push_back(g);
        end
      end
    end
  end

  task automatic set_req(input int k, input int id, input logic [31:0] a, input logic [31:0] b,
                         input bit sub);
    if (id == 0) begin
      a0[k] = a; b0[k] = b;
    end else begin
      a1[k] = a; b1[k] = b;
    end
    sb[k][id] = sub;
    rv[k][id] = 1'b1;
  endtask

  task automatic wait_accept(input int k, input int id, output bit ok);
    bit acc;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      acc = rdy[k][id] && rv[k][id];
      @(posedge clk); #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("accept");
  endtask

  // Runs one operation on instance k; returns the result, latency and HI carry-in.
  task automatic run_op(input int k, input int id, input logic [31:0] a, input logic [31:0] b,
                        input bit sub, output logic [31:0] r, output logic co, output logic ov,
                        output logic oid, output int lat, output logic hcin);
    bit ok;
    r = 'x; co = 'x; ov = 'x; oid = 'x; lat = -1; hcin = 'x;
    @(posedge clk); #1;
    set_req(k, id, a, b, sub);
    wait_accept(k, id, ok);
    rv[k][id] = 1'b0;
    if (!ok) return;
    if (id == 0) begin
      a0[k] = $urandom; b0[k] = $urandom;
    end else begin
      a1[k] = $urandom; b1[k] = $urandom;
    end
    @(posedge clk); #1;
    hcin = acin[k];
    lat = 2;
    while (!vld[k] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!vld[k]) begin
      fail_now("rsp_valid");
      return;
    end
    r = rr[k]; co = rco[k]; ov = rov[k]; oid = rid[k];
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom % 6)
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] r, snap;
    logic        co, ov, oid, hc;
    int          lat;
    bit          ok;

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; rv[k] = 2'b00; sb[k] = 2'b00; rrdy[k] = 1'b1;
      a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Directed arithmetic on the round-robin instance.
    run_op(0, 0, 32'h0000FFFF, 32'h00000001, 1'b0, r, co, ov, oid, lat, hc);
    $display("carry chain: r=%h cout=%0b ovf=%0b id=%0b lat=%0d hi_cin=%0b", r, co, ov, oid, lat, hc);
    chk("carry r", r, 32'h00010000);
    chk("carry cout", 32'(co), 32'h0);
    chk("carry ovf", 32'(ov), 32'h0);
    chk("carry id", 32'(oid), 32'h0);
    chk("carry latency", 32'(lat), 32'd3);
    chk("carry hi cin", 32'(hc), 32'h1);

    run_op(0, 0, 32'h7FFFFFFF, 32'h00000001, 1'b0, r, co, ov, oid, lat, hc);
    $display("signed ovf: r=%h cout=%0b ovf=%0b", r, co, ov);
    chk("ovf r", r, 32'h80000000);
    chk("ovf ovf", 32'(ov), 32'h1);
    chk("ovf cout", 32'(co), 32'h0);

    run_op(0, 0, 32'hFFFFFFFF, 32'h00000001, 1'b0, r, co, ov, oid, lat, hc);
    $display("wrap: r=%h cout=%0b ovf=%0b", r, co, ov);
    chk("wrap r", r, 32'h0);
    chk("wrap cout", 32'(co), 32'h1);
    chk("wrap ovf", 32'(ov), 32'h0);

    run_op(0, 1, 32'd5, 32'd7, 1'b1, r, co, ov, oid, lat, hc);
    $display("sub 5-7: r=%h cout=%0b id=%0b", r, co, oid);
    chk("sub57 r", r, 32'hFFFFFFFE);
    chk("sub57 cout", 32'(co), 32'h0);
    chk("sub57 id", 32'(oid), 32'h1);

    run_op(0, 1, 32'd7, 32'd5, 1'b1, r, co, ov, oid, lat, hc);
    $display("sub 7-5: r=%h cout=%0b id=%0b", r, co, oid);
    chk("sub75 r", r, 32'h2);
    chk("sub75 cout", 32'(co), 32'h1);

    // Round-robin: both requesters held valid.
    gq0.delete();
    @(posedge clk); #1;
    set_req(0, 0, 32'd1, 32'd2, 1'b0);
    set_req(0, 1, 32'd9, 32'd3, 1'b1);
    for (int n = 0; n < 40 && gq0.size() < 4; n++) begin
      @(posedge clk); #1;
    end
    rv[0] = 2'b00;
    if (gq0.size() < 4) fail_now("rr grants");
    else begin
      $display("rr grants: %0d %0d %0d %0d", gq0[0], gq0[1], gq0[2], gq0[3]);
      for (int i = 0; i < 4; i++) chk($sformatf("rr grant %0d", i), 32'(gq0[i]), 32'(i % 2));
    end
    repeat (6) @(posedge clk);
    #1;

    // Fixed priority on the second instance.
    gq1.delete();
    set_req(1, 0, 32'd4, 32'd4, 1'b0);
    set_req(1, 1, 32'd8, 32'd1, 1'b0);
    for (int n = 0; n < 40 && gq1.size() < 3; n++) begin
      @(posedge clk); #1;
    end
    rv[1] = 2'b00;
    if (gq1.size() < 3) fail_now("fixed grants");
    else begin
      $display("fixed grants: %0d %0d %0d", gq1[0], gq1[1], gq1[2]);
      for (int i = 0; i < 3; i++) chk($sformatf("fixed grant %0d", i), 32'(gq1[i]), 32'h0);
    end
    repeat (6) @(posedge clk);
    #1;

    // Backpressure in DONE.
    rrdy[0] = 1'b0;
    set_req(0, 0, 32'h12345678, 32'h11111111, 1'b0);
    wait_accept(0, 0, ok);
    rv[0] = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    snap = rr[0];
    chk("bp valid", 32'(vld[0]), 32'h1);
    chk("bp r", snap, 32'h23456789);
    rv[0] = 2'b11;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      $display("backpressure cycle %0d: valid=%0b r=%h ready=%b", n, vld[0], rr[0], rdy[0]);
      chk("bp hold valid", 32'(vld[0]), 32'h1);
      chk("bp hold r", rr[0], snap);
      chk("bp ready", 32'(rdy[0]), 32'h0);
    end
    rrdy[0] = 1'b1;
    rv[0] = 2'b00;
    @(posedge clk); #1;
    chk("bp release", 32'(vld[0]), 32'h0);

    // Reset during HI.
    set_req(0, 1, 32'hAAAA5555, 32'h0F0F0F0F, 1'b1);
    wait_accept(0, 1, ok);
    rv[0] = 2'b00;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    $display("reset in HI: valid=%0b r=%h cout=%0b ovf=%0b id=%0b", vld[0], rr[0], rco[0], rov[0], rid[0]);
    chk("rst valid", 32'(vld[0]), 32'h0);
    chk("rst r", rr[0], 32'h0);
    chk("rst id", 32'(rid[0]), 32'h0);
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      chk("rst no rsp", 32'(vld[0]), 32'h0);
    end

    // Random per-cycle stimulus on both instances, model checks every cycle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        rv[k]   = 2'($urandom);
        sb[k]   = 2'($urandom);
        a0[k]   = rand_word();
        b0[k]   = rand_word();
        a1[k]   = rand_word();
        b1[k]   = rand_word();
        rrdy[k] = ($urandom % 4) != 0;
        rst[k]  = ($urandom % 150) == 0;
      end
      if (cyc % 500 == 0) $display("random cycle %0d: checks=%0d errors=%0d", cyc, checks, errors);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; rv[k] = 2'b00; rrdy[k] = 1'b1;
    end
    repeat (8) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
